// File: rtl/mulw_seq_vec_mul_pkg.sv
// Shared types and constants for the sequential multi-word multiplier.
// Holds the FSM state encoding, default geometry and a counter-sizing helper.
package mulw_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int MULW_W  = 16;
   localparam int MULW_NW = 2;

   // Bits needed to count 0..n-1, never less than one so NW=1 still gets a counter.
   function automatic int clog2_min1(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/mulw_seq_vec_mul_if.sv
// Operand/result handshake bundle between operand source, multiplier and consumer.
// master = source/consumer side, slave = multiplier side.
interface mulw_seq_vec_mul_if
   import mulw_pkg::*;
#(
   parameter int W  = MULW_W,
   parameter int NW = MULW_NW
);
   logic                  in_valid;
   logic                  in_ready;
   logic [NW*W-1:0]       a;
   logic [NW*W-1:0]       b;
   logic                  out_valid;
   logic                  out_ready;
   logic [2*NW*W-1:0]     y;
   logic                  busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, y, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, y, busy
   );
endinterface

// File: rtl/mulw_seq_vec_mul_pp_unit.sv
// Purpose: one W x W word product, zero-extended and aligned to word slot (i+j).
// Latency: combinational.
// Backpressure: none, pure datapath.
module mulw_pp_unit
   import mulw_pkg::*;
#(
   parameter int W  = MULW_W,
   parameter int NW = MULW_NW,
   parameter int SW = clog2_min1(2*NW-1)
) (
   input  logic [W-1:0]        a_j,
   input  logic [W-1:0]        b_i,
   input  logic [SW-1:0]       shift_idx,
   output logic [2*NW*W-1:0]   pp
);
   localparam int PW = 2*NW*W;

   logic [2*W-1:0] prod;
   logic [PW-1:0]  prod_ext;

   assign prod     = {{W{1'b0}}, a_j} * {{W{1'b0}}, b_i};
   assign prod_ext = PW'(prod);
   assign pp       = prod_ext << (W * shift_idx);

endmodule

// File: rtl/mulw_seq_vec_mul.sv
// Purpose: unsigned NW-word x NW-word multiply on one shared W x W multiplier.
// Latency: out_valid rises NW*NW edges after accept; one op in flight at a time.
// Backpressure: result held in DONE until out_ready; in_ready low while busy.
module mulw_seq_vec_mul
   import mulw_pkg::*;
#(
   parameter int W  = MULW_W,
   parameter int NW = MULW_NW
) (
   input  logic               clk,
   input  logic               rst,
   mulw_seq_vec_mul_if.slave  bus
);
   localparam int CW = clog2_min1(NW);
   localparam int SW = clog2_min1(2*NW-1);
   localparam int PW = 2*NW*W;

   state_t            state;
   state_t            state_nx;
   logic [CW-1:0]     i_q;
   logic [CW-1:0]     j_q;
   logic [NW*W-1:0]   a_q;
   logic [NW*W-1:0]   b_q;
   logic [PW-1:0]     acc_q;
   logic [PW-1:0]     pp;
   logic [W-1:0]      a_word;
   logic [W-1:0]      b_word;
   logic [SW-1:0]     shift_idx;
   logic              accept;
   logic              last_step;
   logic              j_wrap;

   assign accept    = bus.in_valid && (state == IDLE);
   assign j_wrap    = (j_q == CW'(NW-1));
   assign last_step = j_wrap && (i_q == CW'(NW-1));

   assign a_word    = a_q[int'(j_q)*W +: W];
   assign b_word    = b_q[int'(i_q)*W +: W];
   assign shift_idx = SW'(i_q) + SW'(j_q);

   mulw_pp_unit #(
      .W  (W),
      .NW (NW),
      .SW (SW)
   ) u_pp (
      .a_j       (a_word),
      .b_i       (b_word),
      .shift_idx (shift_idx),
      .pp        (pp)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept)        state_nx = CALC;
         CALC:    if (last_step)     state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default:                    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Operands are only captured on accept, so input wiggles mid-op are harmless.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         i_q   <= '0;
         j_q   <= '0;
      end else if (accept) begin
         a_q   <= bus.a;
         b_q   <= bus.b;
         acc_q <= '0;
         i_q   <= '0;
         j_q   <= '0;
      end else if (state == CALC) begin
         acc_q <= acc_q + pp;
         if (j_wrap) begin
            j_q <= '0;
            i_q <= i_q + 1'b1;
         end else begin
            j_q <= j_q + 1'b1;
         end
      end
   end

   // y tracks the accumulator, which is frozen outside CALC until the next accept.
   assign bus.y         = acc_q;
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mulw_seq_vec_mul.sv
// Bench for mulw_seq_vec_mul in two geometries (16b x 2 words, 8b x 4 words).
// Both share 32-bit operands, so one stimulus path and one reference model serve both.
module tb_mulw_seq_vec_mul;
   import mulw_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s       [2];
   logic        in_valid_s  [2];
   logic        out_ready_s [2];
   logic [31:0] a_s         [2];
   logic [31:0] b_s         [2];
   logic        in_ready_o  [2];
   logic        out_valid_o [2];
   logic        busy_o      [2];
   logic [63:0] y_o         [2];

   int checks = 0;
   int errors = 0;
   int acc_n [2] = '{0, 0};
   int out_n [2] = '{0, 0};

   mulw_seq_vec_mul_if #(.W(16), .NW(2)) bus0 ();
   mulw_seq_vec_mul_if #(.W(8),  .NW(4)) bus1 ();

   assign bus0.in_valid  = in_valid_s[0];
   assign bus0.a         = a_s[0];
   assign bus0.b         = b_s[0];
   assign bus0.out_ready = out_ready_s[0];
   assign in_ready_o[0]  = bus0.in_ready;
   assign out_valid_o[0] = bus0.out_valid;
   assign busy_o[0]      = bus0.busy;
   assign y_o[0]         = bus0.y;

   assign bus1.in_valid  = in_valid_s[1];
   assign bus1.a         = a_s[1];
   assign bus1.b         = b_s[1];
   assign bus1.out_ready = out_ready_s[1];
   assign in_ready_o[1]  = bus1.in_ready;
   assign out_valid_o[1] = bus1.out_valid;
   assign busy_o[1]      = bus1.busy;
   assign y_o[1]         = bus1.y;

   mulw_seq_vec_mul #(.W(16), .NW(2)) dut0 (.clk(clk), .rst(rst_s[0]), .bus(bus0.slave));
   mulw_seq_vec_mul #(.W(8),  .NW(4)) dut1 (.clk(clk), .rst(rst_s[1]), .bus(bus1.slave));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every accept queues A*B, every output handshake must match the oldest entry.
   for (genvar c = 0; c < 2; c++) begin : g_mon
      logic [63:0] q [$];
      always @(negedge clk) begin
         if (rst_s[c]) begin
            q.delete();
         end else begin
            if (in_valid_s[c] && in_ready_o[c]) begin
               q.push_back(64'(a_s[c]) * 64'(b_s[c]));
               acc_n[c]++;
            end
            if (out_valid_o[c] && out_ready_s[c]) begin
               out_n[c]++;
               if (q.size() == 0) chk("spurious_out", out_valid_o[c], 1'b0);
               else               chk("model_y", y_o[c], q.pop_front());
            end
         end
      end
   end

   function automatic logic [31:0] rand32();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic reset_check(input int c);
      rst_s[c] = 1'b1;
      #2;
      chk("rst_y",         y_o[c],         64'h0);
      chk("rst_out_valid", out_valid_o[c], 1'b0);
      chk("rst_in_ready",  in_ready_o[c],  1'b1);
      chk("rst_busy",      busy_o[c],      1'b0);
      tick();
      rst_s[c] = 1'b0;
   endtask

   task automatic run_op(input int c, input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] expy, input int hold);
      int   cyc;
      logic got;
      a_s[c]         = av;
      b_s[c]         = bv;
      in_valid_s[c]  = 1'b1;
      out_ready_s[c] = (hold == 0);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 50) begin
         got = in_ready_o[c];
         tick();
         cyc++;
      end
      chk("accept", got, 1'b1);
      in_valid_s[c] = 1'b0;
      cyc = 0;
      while (!out_valid_o[c] && cyc < 100) begin
         tick();
         cyc++;
      end
      chk("latency",       cyc,           (c == 0) ? 4 : 16);
      chk("y",             y_o[c],        expy);
      chk("done_in_ready", in_ready_o[c], 1'b0);
      chk("done_busy",     busy_o[c],     1'b1);
      for (int k = 0; k < hold; k++) begin
         in_valid_s[c] = 1'($urandom_range(0, 1));
         a_s[c]        = $urandom;
         b_s[c]        = $urandom;
         tick();
         chk("bp_y",        y_o[c],         expy);
         chk("bp_in_ready", in_ready_o[c],  1'b0);
         chk("bp_busy",     busy_o[c],      1'b1);
         chk("bp_valid",    out_valid_o[c], 1'b1);
      end
      // in_valid high across the exit edge must not produce an accept there.
      in_valid_s[c]  = 1'b1;
      out_ready_s[c] = 1'b1;
      tick();
      in_valid_s[c]  = 1'b0;
      out_ready_s[c] = 1'b0;
      chk("exit_out_valid", out_valid_o[c], 1'b0);
      chk("exit_in_ready",  in_ready_o[c],  1'b1);
      chk("exit_busy",      busy_o[c],      1'b0);
      chk("y_retained",     y_o[c],         expy);
   endtask

   task automatic rnd_phase(input int c, input int n);
      int acc;
      int cyc;
      int a0;
      int o0;
      acc = 0;
      cyc = 0;
      a0  = acc_n[c];
      o0  = out_n[c];
      in_valid_s[c] = 1'b0;
      while (acc < n && cyc < n * 60) begin
         out_ready_s[c] = ($urandom_range(0, 3) != 0);
         if (!in_valid_s[c] && $urandom_range(0, 2) == 0) begin
            in_valid_s[c] = 1'b1;
            a_s[c]        = rand32();
            b_s[c]        = rand32();
         end
         if (in_valid_s[c] && in_ready_o[c]) begin
            acc++;
            tick();
            in_valid_s[c] = 1'b0;
            a_s[c]        = $urandom;
            b_s[c]        = $urandom;
         end else begin
            tick();
         end
         cyc++;
      end
      out_ready_s[c] = 1'b1;
      cyc = 0;
      while ((out_n[c] - o0) < acc && cyc < 200) begin
         tick();
         cyc++;
      end
      out_ready_s[c] = 1'b0;
      chk("rnd_accepts",    acc,             n);
      chk("rnd_acc_seen",   acc_n[c] - a0,   acc);
      chk("rnd_handshakes", out_n[c] - o0,   acc);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int c = 0; c < 2; c++) begin
         rst_s[c]       = 1'b1;
         in_valid_s[c]  = 1'b0;
         out_ready_s[c] = 1'b0;
         a_s[c]         = '0;
         b_s[c]         = '0;
      end
      tick();

      // Geometry 16b x 2 words.
      reset_check(0);
      run_op(0, 32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008, 0);
      run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
      run_op(0, 32'h0000_0000, 32'h1234_5678, 64'h0, 0);
      run_op(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 64'(32'hDEAD_BEEF) * 64'(32'h0BAD_F00D), 10);

      // Abort mid-CALC with a large product partially accumulated.
      a_s[0] = 32'hFFFF_FFFF;
      b_s[0] = 32'hFFFF_FFFF;
      in_valid_s[0] = 1'b1;
      tick();
      in_valid_s[0] = 1'b0;
      tick();
      tick();
      chk("mid_busy", busy_o[0], 1'b1);
      rst_s[0] = 1'b1;
      #1;
      chk("abort_out_valid", out_valid_o[0], 1'b0);
      chk("abort_y",         y_o[0],         64'h0);
      chk("abort_in_ready",  in_ready_o[0],  1'b1);
      chk("abort_busy",      busy_o[0],      1'b0);
      tick();
      rst_s[0] = 1'b0;
      run_op(0, 32'd7, 32'd9, 64'd63, 0);

      // Geometry 8b x 4 words.
      reset_check(1);
      run_op(1, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 0);
      run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 3);

      rnd_phase(0, 500);
      rnd_phase(1, 500);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
